// File: rtl/imem_pkg.sv
// imem_pkg: shared tag width, response record and latency bound for the instruction-memory responder
package imem_pkg;
  localparam int TAG_W = 4;
  localparam int MAX_LATENCY = 8;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             err;
  } imem_resp_t;
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (&t) ? TAG_W'(1) : t + TAG_W'(1);
  endfunction
endpackage

// File: rtl/imem_delay_line.sv
// imem_delay_line: LATENCY-stage shift register of responses with synchronous flush
module imem_delay_line
  import imem_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       i_flush,
  input  imem_resp_t i_d,
  output imem_resp_t o_q
);
  imem_resp_t r_q [LATENCY];
  always_ff @(posedge clk) begin
    if (i_flush) begin
      for (int i = 0; i < LATENCY; i++) r_q[i] <= '0;
    end else begin
      r_q[0] <= i_d;
      for (int i = 1; i < LATENCY; i++) r_q[i] <= r_q[i-1];
    end
  end
  assign o_q = r_q[LATENCY-1];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: tagged fixed-latency instruction memory with preload port
module imem_responder
  import imem_pkg::*;
#(
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             proc2Imem_req,
  input  logic [31:0]      proc2Imem_addr,
  output logic             Imem2proc_ack,
  output logic [TAG_W-1:0] Imem2proc_tag,
  output logic             Imem2proc_valid,
  output logic [TAG_W-1:0] Imem2proc_resp_tag,
  output logic [31:0]      Imem2proc_data,
  output logic             Imem2proc_err,
  input  logic             load_en,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_data
);
  localparam int IDX_W = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [29:0] LIMIT = 30'(MEM_WORDS);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  logic [31:0]      r_mem [MEM_WORDS];
  logic [TAG_W-1:0] r_tag;
  logic [OUT_W-1:0] r_out;
  logic             w_oor, w_load_ok, w_ack, w_emit, w_unused;
  logic [IDX_W-1:0] w_idx, w_load_idx;
  imem_resp_t       w_d, w_q;
  assign w_unused   = ^{proc2Imem_addr[1:0], load_addr[1:0]};
  assign w_idx      = proc2Imem_addr[IDX_W+1:2];
  assign w_load_idx = load_addr[IDX_W+1:2];
  assign w_oor      = proc2Imem_addr[31:2] >= LIMIT;
  assign w_load_ok  = load_addr[31:2] < LIMIT;
  assign w_emit     = w_q.valid;
  // a response leaving this cycle frees a slot, so a full responder can still accept
  assign w_ack = proc2Imem_req && !load_en && !rst && (r_out < MAX_OUT || w_emit);
  always_comb begin
    w_d = '{valid: w_ack,
            tag:   w_ack ? r_tag : '0,
            data:  (w_ack && !w_oor) ? r_mem[w_idx] : '0,
            err:   w_ack && w_oor};
  end
  always_ff @(posedge clk) begin
    if (load_en && w_load_ok) r_mem[w_load_idx] <= load_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= TAG_W'(1);
      r_out <= '0;
    end else begin
      if (w_ack) r_tag <= next_tag(r_tag);
      r_out <= (w_ack && !w_emit) ? r_out + OUT_W'(1) :
               (!w_ack && w_emit) ? r_out - OUT_W'(1) : r_out;
    end
  end
  imem_delay_line #(.LATENCY(LATENCY)) u_dly (
    .clk     (clk),
    .i_flush (rst),
    .i_d     (w_d),
    .o_q     (w_q)
  );
  assign Imem2proc_ack      = w_ack;
  assign Imem2proc_tag      = w_d.tag;
  assign Imem2proc_valid    = w_q.valid;
  assign Imem2proc_resp_tag = w_q.tag;
  assign Imem2proc_data     = w_q.data;
  assign Imem2proc_err      = w_q.err;
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory side of the fetch interface. It accepts word-fetch requests from the fetch stage, tags each accepted request, and returns the instruction word with its tag after a fixed, parameterised latency. A preload port lets the testbench or boot logic write program words. It sits between the processor top level and the memory model, replacing the zero-latency instruction memory.

## Interface
- MEM_WORDS, 1024: number of 32-bit words; valid word index 0..MEM_WORDS-1.
- LATENCY, 3: cycles from request acceptance to response; legal range 1..8.
- MAX_OUTSTANDING, 4: maximum accepted-but-undelivered requests; legal range 1..LATENCY.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- proc2Imem_req  in  1  fetch request valid.
- proc2Imem_addr  in  32  byte address; bits [1:0] ignored.
- Imem2proc_ack  out  1  request accepted this cycle (combinational).
- Imem2proc_tag  out  4  tag assigned to the accepted request; 0 when ack=0.
- Imem2proc_valid  out  1  response valid this cycle.
- Imem2proc_resp_tag  out  4  tag of the current response; 0 when valid=0.
- Imem2proc_data  out  32  instruction word; 0 when valid=0.
- Imem2proc_err  out  1  current response addressed an out-of-range word.
- load_en  in  1  preload write strobe.
- load_addr  in  32  preload byte address; bits [1:0] ignored.
- load_data  in  32  preload word.

## Operation
- Word index = addr[31:2]. Out of range when index >= MEM_WORDS.
- Acceptance: ack = req & !load_en & (outstanding < MAX_OUTSTANDING | pipeline emits a response this cycle).
- Preload has priority over fetch. If load_en is high, no request is accepted in that cycle.
- The array is read at the acceptance edge. The word, tag and err flag enter a LATENCY-deep delay line. A later preload does not alter in-flight data.
- Preload writes at the clock edge when load_en=1. Writes to out-of-range addresses are dropped silently.
- Tag counter: starts at 1 and increments on each accept, wrapping 15->1. Tag 0 is never issued.
- Outstanding counter: width is ceil(log2(MAX_OUTSTANDING+1)). It increments on accept and decrements on response. When both occur in the same cycle it holds.
- Out-of-range fetch: response issues with data=32'h0 and err=1. The response still counts as delivered.
- Responses return strictly in acceptance order. The responder has no back-pressure; the consumer must accept every response.

## Timing
- A request accepted at edge E produces a response visible during the cycle beginning at edge E+LATENCY-1. With LATENCY=1, the response appears the cycle after acceptance.
- Throughput is one request per cycle whenever MAX_OUTSTANDING=LATENCY.
- Reset values: valid=0, resp_tag=0, data=0, err=0, tag counter=1, outstanding=0, delay line empty. ack follows its equation (0 while rst=1).
- Reset mid-operation flushes all in-flight responses; none are emitted afterward. Memory contents are retained across reset.
- At the full boundary (outstanding=MAX_OUTSTANDING), a request is accepted only if a response emits in the same cycle.

## Structure
- Package imem_pkg holds: TAG_W=4; typedef imem_resp_t {valid, tag, data, err}; the MAX_LATENCY=8 constant.
- Sub-module imem_delay_line: a parameterised LATENCY-stage shift register of imem_resp_t with synchronous flush.
- The top level holds the array, the acceptance logic, and the tag and outstanding counters.

## Test plan
- Preload words 0..3 with 32'hA0..A3. Issue back-to-back requests at addresses 0,4,8,12 with LATENCY=3. Required: ack every cycle; tags 1,2,3,4; responses A0..A3 in the same order, each exactly 3 cycles after its accept.
- LATENCY=3, MAX_OUTSTANDING=2, request held high continuously: ack pattern 1,1,0,1,1,0...; the outstanding counter never exceeds 2.
- Fetch at address 32'h0000_1000 with MEM_WORDS=1024: response has data=0 and err=1, with a valid tag.
- Assert load_en and req together: ack=0 that cycle and the word is written. Next cycle, re-request the same address: response returns the new data. Separately, a preload issued after an accept does not change that in-flight response.
- Issue 17 accepts: tags run 1..15, then 1, 2; tag 0 never appears.
- Assert rst with 3 requests in flight: no responses emerge afterward. Tag counter returns to 1; previously loaded memory still reads back correctly.
